// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t : controller states (2-bit encoding)
//   clog2   : width of a counter able to hold 0..value-1 (never below 1)
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Request/result bundle of the bit-serial subtractor.
//   start          : request, sampled when the subtractor can accept work
//   data_a, data_b : minuend / subtrahend, captured on an accepted start
//   busy           : bits are being processed
//   done           : one-cycle pulse, diff/b_out valid
//   diff, b_out    : (a - b) mod 2^WIDTH and final borrow (a < b)
// master drives requests (client side), slave is the subtractor.
interface serial_sub_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;

  modport master (
    output start, data_a, data_b,
    input  busy, done, diff, b_out
  );

  modport slave (
    input  start, data_a, data_b,
    output busy, done, diff, b_out
  );
endinterface

// File: rtl/serial_sub_full_sub_bit.sv
// One-bit full subtractor: a - b - bin.
//   a, b, bin : operand bits and incoming borrow
//   d         : difference bit
//   bout      : outgoing borrow
module full_sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, dominates everything
//   bus : serial_sub_if slave (start/data_a/data_b in, busy/done/diff/b_out out)
// A start seen in IDLE, or on the edge that leaves DONE, latches the operands
// and runs WIDTH bit steps; the final step loads diff/b_out and raises done for
// one cycle. Starts sampled while RUN is in progress are dropped.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  serial_sub_if.slave bus
);
  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_reg;
  logic             bw_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             b_out_reg;

  logic             d_bit;
  logic             bw_next;
  logic [WIDTH-1:0] res_next;
  logic             accept;

  full_sub_bit u_bit (
    .a    (a_sh_reg[0]),
    .b    (b_sh_reg[0]),
    .bin  (bw_reg),
    .d    (d_bit),
    .bout (bw_next)
  );

  // New bits enter at the MSB so after WIDTH steps bit 0 holds the LSB result.
  assign res_next = {d_bit, res_reg[WIDTH-1:1]};

  // DONE lasts exactly one cycle, so the edge leaving it may accept the next
  // request; this keeps back-to-back operations at WIDTH+1 cycles each.
  assign accept = bus.start && (state_reg == IDLE || state_reg == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      res_reg   <= '0;
      bw_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      diff_reg  <= '0;
      b_out_reg <= 1'b0;
    end else if (accept) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
      a_sh_reg  <= bus.data_a;
      b_sh_reg  <= bus.data_b;
      bw_reg    <= 1'b0;
      busy_reg  <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
        end
        RUN: begin
          a_sh_reg <= a_sh_reg >> 1;
          b_sh_reg <= b_sh_reg >> 1;
          res_reg  <= res_next;
          bw_reg   <= bw_next;
          cnt_reg  <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            diff_reg  <= res_next;
            b_out_reg <= bw_next;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;
  assign bus.diff  = diff_reg;
  assign bus.b_out = b_out_reg;

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;
  localparam int W = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  serial_sub_if #(.WIDTH(W)) bus ();
  serial_sub_if #(.WIDTH(8)) bus8 ();

  serial_sub #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  serial_sub #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           done_cyc;
  } exp_t;

  exp_t exp_q[$];
  logic prev_done;

  // Monitor: pops one expectation per done pulse.
  initial prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t         e;
    logic [W-1:0] ediff;
    logic         ebo;
    logic [W-1:0] back;
    if (!rst) begin
      checks++;
      if (bus.busy && bus.done) begin
        errors++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b, required not both high", bus.busy, bus.done);
      end
      if (bus.done) begin
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_consecutive: done high two cycles in a row at cyc %0d", cyc);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: done at cyc %0d with nothing outstanding, diff=%h b_out=%0b", cyc, bus.diff, bus.b_out);
        end else begin
          e     = exp_q.pop_front();
          ediff = e.a - e.b;
          ebo   = (e.a < e.b);
          back  = bus.diff + e.b;
          $display("txn a=%h b=%h diff=%h b_out=%0b cyc=%0d", e.a, e.b, bus.diff, bus.b_out, cyc);
          if (bus.diff !== ediff) begin
            errors++;
            $display("FAIL diff a=%h b=%h: got %h, required %h", e.a, e.b, bus.diff, ediff);
          end
          checks++;
          if (bus.b_out !== ebo) begin
            errors++;
            $display("FAIL b_out a=%h b=%h: got %0b, required %0b", e.a, e.b, bus.b_out, ebo);
          end
          checks++;
          if (back !== e.a) begin
            errors++;
            $display("FAIL sum_back a=%h b=%h: diff+b=%h, required %h", e.a, e.b, back, e.a);
          end
          checks++;
          if (cyc != e.done_cyc) begin
            errors++;
            $display("FAIL done_latency a=%h b=%h: done at cyc %0d, required %0d", e.a, e.b, cyc, e.done_cyc);
          end
        end
      end
      prev_done = bus.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Issue one operation starting just after a rising edge. hold keeps start
  // high afterwards; noise changes operands and pulses start while running.
  // Returns just after edge E_W, so the next call lands on E_W+1.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit hold, input bit noise);
    exp_t e;
    bus.start  = 1'b1;
    bus.data_a = a;
    bus.data_b = b;
    e.a = a;
    e.b = b;
    e.done_cyc = cyc + 1 + W;
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    if (noise) begin
      bus.data_a = ~a;
      bus.data_b = ~b;
      @(posedge clk); #1;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (W - 2) @(posedge clk);
    end else begin
      repeat (W) @(posedge clk);
    end
    #1;
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0b, required %0b", name, got, req);
    end
  endtask

  initial begin
    int n;
    int c0;
    bit found;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.data_a = '0;
    bus.data_b = '0;
    bus8.start = 1'b0;
    bus8.data_a = '0;
    bus8.data_b = '0;
    checks = 0;
    errors = 0;
    repeat (3) @(posedge clk);
    #1;
    check_bit("reset_busy", bus.busy, 1'b0);
    check_bit("reset_done", bus.done, 1'b0);
    check_bit("reset_b_out", bus.b_out, 1'b0);
    checks++;
    if (bus.diff !== 4'h0) begin
      errors++;
      $display("FAIL reset_diff: got %h, required 0", bus.diff);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Busy must rise right after the accepting edge.
    bus.start = 1'b1; bus.data_a = 4'd9; bus.data_b = 4'd3;
    begin
      exp_t e;
      e.a = 4'd9; e.b = 4'd3; e.done_cyc = cyc + 1 + W;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_bit("busy_after_start", bus.busy, 1'b1);
    repeat (W) @(posedge clk);
    #1;

    issue(4'd3, 4'd9, 1'b0, 1'b0);
    issue(4'd0, 4'd1, 1'b0, 1'b0);
    issue(4'd15, 4'd15, 1'b0, 1'b0);
    issue(4'd9, 4'd3, 1'b0, 1'b1);
    issue(4'd5, 4'd12, 1'b1, 1'b0);
    issue(4'd12, 4'd5, 1'b1, 1'b0);
    issue(4'd7, 4'd0, 1'b1, 1'b0);
    issue(4'd3, 4'd9, 1'b0, 1'b0);

    // Reset during RUN: result discarded, no done afterwards.
    bus.start = 1'b1; bus.data_a = 4'd14; bus.data_b = 4'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_bit("rst_busy", bus.busy, 1'b0);
    check_bit("rst_done", bus.done, 1'b0);
    check_bit("rst_b_out", bus.b_out, 1'b0);
    checks++;
    if (bus.diff !== 4'h0) begin
      errors++;
      $display("FAIL rst_diff: got %h, required 0", bus.diff);
    end
    repeat (W + 3) @(posedge clk);
    #1;
    issue(4'd14, 4'd1, 1'b0, 1'b0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(4'(a), 4'(b), 1'b0, 1'b0);
      end
    end

    // WIDTH=8 spot check.
    bus8.start = 1'b1; bus8.data_a = 8'h00; bus8.data_b = 8'hFF;
    c0 = cyc + 1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 40) begin
      @(negedge clk);
      if (bus8.done) found = 1'b1;
      n++;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL w8_timeout: no done within 40 cycles, required done");
    end else begin
      $display("txn w8 a=00 b=ff diff=%h b_out=%0b cyc=%0d", bus8.diff, bus8.b_out, cyc);
      checks++;
      if (bus8.diff !== 8'h01) begin
        errors++;
        $display("FAIL w8_diff: got %h, required 01", bus8.diff);
      end
      check_bit("w8_b_out", bus8.b_out, 1'b1);
      checks++;
      if (cyc != c0 + 8) begin
        errors++;
        $display("FAIL w8_latency: done at cyc %0d, required %0d", cyc, c0 + 8);
      end
    end

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
